// File: rtl/uart_tx_queue.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter's start/data/busy/done handshake.
// Bursty producers push freely; bytes are launched one at a time as the transmitter frees up.
module uart_tx_queue #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   tx_start,
  output logic [DATA_W-1:0]      tx_data,
  input  logic                   tx_busy,
  input  logic                   tx_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_queue: DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop;
  logic              push;
  logic              drop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign tx_start = (state == LAUNCH);

  // Pop only from IDLE so tx_data never moves under an in-flight byte; flush wins over pop.
  always_comb begin
    pop  = (state == IDLE) && !empty && !tx_busy && !flush;
    push = wr_en && !flush && (!full || pop);
    drop = wr_en && !flush && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= drop;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx_data <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        tx_data <= mem[rd_ptr];
      end
    end
  end

  // A transmitter that finishes before we ever see busy still returns us to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pop) state_next = LAUNCH;
      LAUNCH:    state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_done) begin
          state_next = IDLE;
        end else if (tx_busy) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: if (tx_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  a_data_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (state != IDLE) |=> $stable(tx_data));

  a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
    count <= CNT_W'(DEPTH));

  a_start_pulse: assert property (@(posedge clk) disable iff (!reset_n)
    tx_start |=> !tx_start);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue with a behavioural transmitter and byte scoreboard.
// The transmitter frame is scaled down to keep simulation short.
module tb_uart_tx_queue;

  localparam int DEPTH    = 16;
  localparam int DATA_W   = 8;
  localparam int BIT_CLKS = 4;
  localparam int FRAME    = 10 * BIT_CLKS;

  logic              clk;
  logic              reset_n;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              flush;
  logic              full;
  logic              empty;
  logic [4:0]        count;
  logic              overflow;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;
  logic              tx_done;

  uart_tx_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [DATA_W-1:0] sb[$];

  typedef enum {X_IDLE, X_PEND, X_BUSY} xstate_t;
  xstate_t           x_state = X_IDLE;
  logic [DATA_W-1:0] x_byte;
  int                x_cnt = 0;
  logic              prev_start = 1'b0;
  logic              hold = 1'b0;
  logic              gap_check = 1'b0;
  logic              rand_lat = 1'b0;
  logic              have_done = 1'b0;
  int                n_starts = 0;
  int                n_done = 0;
  int                start_cyc = 0;
  int                done_cyc = 0;
  int                unstable = 0;
  int                ovf_cnt = 0;
  int                max_count = 0;

  // Transmitter model: reacts on the falling edge, pops the scoreboard at each launch.
  always @(negedge clk) begin
    if (!reset_n) begin
      x_state    = X_IDLE;
      tx_busy    = 1'b0;
      tx_done    = 1'b0;
      prev_start = 1'b0;
    end else begin
      tx_done = 1'b0;
      if (tx_start && prev_start) begin
        checks++;
        errors++;
        $display("[TB] FAIL start_width: tx_start got 1 for 2+ cycles, required single pulse");
      end
      if (tx_start && !prev_start) begin
        n_starts++;
        start_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_start: tx_data=%02h launched, scoreboard empty", tx_data);
        end else begin
          logic [DATA_W-1:0] exp_byte;
          exp_byte = sb.pop_front();
          if (tx_data !== exp_byte) begin
            errors++;
            $display("[TB] FAIL sb_order: tx_data got %02h expected %02h", tx_data, exp_byte);
          end
        end
        if (gap_check && have_done) begin
          checks++;
          if (cyc - done_cyc != 2) begin
            errors++;
            $display("[TB] FAIL launch_gap: got %0d cycles after tx_done, required 2", cyc - done_cyc);
          end
        end
        x_byte = tx_data;
        x_cnt  = rand_lat ? int'($urandom_range(0, 3)) : 0;
        if (x_cnt == 0) begin
          x_state = X_BUSY;
          x_cnt   = FRAME;
        end else begin
          x_state = X_PEND;
        end
      end else begin
        case (x_state)
          X_PEND: begin
            x_cnt--;
            if (x_cnt == 0) begin
              x_state = X_BUSY;
              x_cnt   = FRAME;
            end
          end
          X_BUSY: begin
            if (tx_data !== x_byte) unstable++;
            x_cnt--;
            if (x_cnt == 0) begin
              x_state   = X_IDLE;
              tx_done   = 1'b1;
              done_cyc  = cyc;
              have_done = 1'b1;
              n_done++;
            end
          end
          default: ;
        endcase
      end
      prev_start = tx_start;
      tx_busy    = (x_state == X_BUSY) || hold;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (overflow === 1'b1) ovf_cnt++;
      if (int'(count) > max_count) max_count = int'(count);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [DATA_W-1:0] b, input bit expect_accept);
    wr_en   = 1'b1;
    wr_data = b;
    if (expect_accept) sb.push_back(b);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(sb.size() == 0 && x_state == X_IDLE && !tx_busy && empty) && n < 5000) begin
      step();
      n++;
    end
    step();
    step();
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("[TB] FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!tx_busy && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("[TB] FAIL %s_busy: tx_busy got 0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start: got %b expected 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %02h expected 00", tx_data); end
    reset_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single();
    int s0 = n_starts;
    int push_cyc;
    int n = 0;
    push_byte(8'h41, 1'b1);
    push_cyc = cyc;
    checks++; if (count !== 5'd1) begin errors++; $display("[TB] FAIL single_count1: got %0d expected 1", count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("[TB] FAIL single_nonempty: got %b expected 0", empty); end
    step();
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL single_count0: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL single_empty: got %b expected 1", empty); end
    while (n_starts == s0 && n < 20) begin step(); n++; end
    checks++; if (start_cyc - push_cyc != 1) begin errors++; $display("[TB] FAIL single_latency: got %0d edges expected 1", start_cyc - push_cyc); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("[TB] FAIL single_data: got %02h expected 41", tx_data); end
    wait_drain("single");
    checks++; if (n_starts - s0 != 1) begin errors++; $display("[TB] FAIL single_starts: got %0d expected 1", n_starts - s0); end
  endtask

  task automatic test_burst();
    int s0;
    hold = 1'b1;
    step();
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i), 1'b1);
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL burst_full: got %b expected 1", full); end
    checks++; if (count !== 5'd16) begin errors++; $display("[TB] FAIL burst_count: got %0d expected 16", count); end
    s0        = n_starts;
    have_done = 1'b0;
    gap_check = 1'b1;
    hold      = 1'b0;
    wait_drain("burst");
    gap_check = 1'b0;
    checks++; if (n_starts - s0 != 16) begin errors++; $display("[TB] FAIL burst_starts: got %0d expected 16", n_starts - s0); end
    checks++; if (unstable != 0) begin errors++; $display("[TB] FAIL burst_stable: got %0d data changes expected 0", unstable); end
  endtask

  task automatic test_overflow();
    int ovf0;
    hold = 1'b1;
    step();
    for (int i = 0; i < 16; i++) push_byte(8'h60 + 8'(i), 1'b1);
    ovf0 = ovf_cnt;
    push_byte(8'hAA, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_pulse: got %b expected 1", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 16", count); end
    step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
    checks++; if (ovf_cnt - ovf0 != 1) begin errors++; $display("[TB] FAIL ovf_width: got %0d cycles expected 1", ovf_cnt - ovf0); end
    hold = 1'b0;
    push_byte(8'hAA, 1'b1);
    checks++; if (count !== 5'd16) begin errors++; $display("[TB] FAIL ovf_coincident_count: got %0d expected 16", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_coincident: got %b expected 0", overflow); end
    wait_drain("overflow");
    checks++; if (ovf_cnt - ovf0 != 1) begin errors++; $display("[TB] FAIL ovf_total: got %0d expected 1", ovf_cnt - ovf0); end
  endtask

  task automatic test_flush_full();
    int s0;
    int ovf0 = ovf_cnt;
    hold = 1'b1;
    step();
    for (int i = 0; i < 16; i++) push_byte(8'h70 + 8'(i), 1'b0);
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hBB;
    step();
    flush = 1'b0;
    wr_en = 1'b0;
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL flushfull_full: got %b expected 0", full); end
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL flushfull_count: got %0d expected 0", count); end
    step();
    checks++; if (ovf_cnt != ovf0) begin errors++; $display("[TB] FAIL flushfull_ovf: got %0d pulses expected 0", ovf_cnt - ovf0); end
    s0   = n_starts;
    hold = 1'b0;
    repeat (10) step();
    checks++; if (n_starts != s0) begin errors++; $display("[TB] FAIL flushfull_starts: got %0d expected 0", n_starts - s0); end
  endtask

  task automatic test_flush();
    int s0 = n_starts;
    for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i), 1'b1);
    wait_busy("flush");
    repeat (3) step();
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    sb.delete();
    step();
    flush = 1'b0;
    wr_en = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL flush_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL flush_empty: got %b expected 1", empty); end
    checks++; if (tx_data !== 8'h30) begin errors++; $display("[TB] FAIL flush_inflight: got %02h expected 30", tx_data); end
    wait_drain("flush");
    repeat (20) step();
    checks++; if (n_starts - s0 != 1) begin errors++; $display("[TB] FAIL flush_starts: got %0d expected 1", n_starts - s0); end
  endtask

  task automatic test_reset_mid();
    int s0;
    for (int i = 0; i < 4; i++) push_byte(8'h50 + 8'(i), 1'b1);
    wait_busy("rstmid");
    repeat (5) step();
    checks++; if (count !== 5'd3) begin errors++; $display("[TB] FAIL rstmid_queued: got %0d expected 3", count); end
    reset_n = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_start: got %b expected 0", tx_start); end
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL rstmid_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_empty: got %b expected 1", empty); end
    sb.delete();
    step();
    reset_n = 1'b1;
    s0 = n_starts;
    repeat (30) step();
    checks++; if (n_starts != s0) begin errors++; $display("[TB] FAIL rstmid_quiet: got %0d starts expected 0", n_starts - s0); end
    push_byte(8'h5A, 1'b1);
    step();
    checks++; if (tx_start !== 1'b1) begin errors++; $display("[TB] FAIL rstlaunch_pre: got %b expected 1", tx_start); end
    reset_n = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL rstlaunch_drop: got %b expected 0", tx_start); end
    sb.delete();
    step();
    reset_n = 1'b1;
    s0 = n_starts;
    repeat (10) step();
    checks++; if (n_starts != s0) begin errors++; $display("[TB] FAIL rstlaunch_quiet: got %0d starts expected 0", n_starts - s0); end
  endtask

  task automatic test_random();
    int s0   = n_starts;
    int ovf0 = ovf_cnt;
    int n;
    rand_lat  = 1'b1;
    max_count = 0;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) step();
      n = 0;
      while (full && n < 3000) begin step(); n++; end
      if (n >= 3000) begin
        checks++;
        errors++;
        $display("[TB] FAIL random_throttle: full stuck for %0d cycles, required to drain", n);
      end
      push_byte(8'($urandom), 1'b1);
    end
    wait_drain("random");
    rand_lat = 1'b0;
    checks++; if (n_starts - s0 != 40) begin errors++; $display("[TB] FAIL random_starts: got %0d expected 40", n_starts - s0); end
    checks++; if (max_count > DEPTH) begin errors++; $display("[TB] FAIL random_maxcount: got %0d expected <= 16", max_count); end
    checks++; if (ovf_cnt != ovf0) begin errors++; $display("[TB] FAIL random_ovf: got %0d pulses expected 0", ovf_cnt - ovf0); end
    checks++; if (unstable != 0) begin errors++; $display("[TB] FAIL random_stable: got %0d data changes expected 0", unstable); end
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    flush   = 1'b0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_flush_full();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
